// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, instruction field positions,
// stage state encoding, the registered control record and the opcode classifier.
package isa_pkg;

   typedef enum logic [5:0] {
      OP_ADD  = 6'h00, OP_ADDI = 6'h01,
      OP_SUB  = 6'h02, OP_SUBI = 6'h03,
      OP_MUL  = 6'h04, OP_MULI = 6'h05,
      OP_OR   = 6'h06, OP_ORI  = 6'h07,
      OP_AND  = 6'h08, OP_ANDI = 6'h09,
      OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
      OP_LDW  = 6'h0C, OP_STW  = 6'h0D,
      OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
      OP_JR   = 6'h10, OP_HALT = 6'h11
   } opcode_e;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } id_state_t;

   // Width-independent part of the ID/EX record; opcode is kept raw so illegal codes survive.
   typedef struct packed {
      logic [5:0] opcode;
      logic       we;
      logic       is_load;
      logic       illegal;
   } id_ex_t;

   typedef struct packed {
      logic use_rs;
      logic use_rt;
      logic dst_rd;
      logic dst_rt;
      logic is_load;
      logic illegal;
   } dec_t;

   function automatic dec_t decode_op(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
            d.dst_rd = 1'b1;
         end
         OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
            d.use_rs = 1'b1;
            d.dst_rt = 1'b1;
         end
         OP_LDW: begin
            d.use_rs  = 1'b1;
            d.dst_rt  = 1'b1;
            d.is_load = 1'b1;
         end
         OP_STW, OP_BEQ: begin
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
         end
         OP_BZ, OP_JR: d.use_rs = 1'b1;
         OP_HALT: ;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port, r0 fixed at zero
// and write-through bypass so a read of the register being written sees the new data.
module regfile_bypass #(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 32,
   localparam int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // NOTE: the array is reset entry by entry because the architecture requires all registers
   // to read zero after reset; this forces flops rather than a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
      if (addr == '0)
         return '0;
      else if (wr_en && wr_addr == addr)
         return wr_data;
      else
         return mem[addr];
   endfunction

   assign rd_data_a = read_port(rd_addr_a);
   assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: rtl/id_stage_hs.sv
// Instruction-decode stage with valid/ready handshakes, load-use bubble, flush and HALT.
// Define ID_PERF_CNT_EN to add the saturating stall_cnt / bubble_cnt outputs.
module id_stage_hs
   import isa_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 32,
   parameter  int PC_W     = 32,
   localparam int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [31:0]       if_inst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [PC_W-1:0]   ex_pc,
   output logic [5:0]        ex_opcode,
   output logic [REG_AW-1:0] ex_rs_addr,
   output logic [REG_AW-1:0] ex_rt_addr,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [REG_AW-1:0] ex_dst_addr,
   output logic              ex_we,
   output logic              ex_is_load,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_illegal,
   output logic              halted
`ifdef ID_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   logic [5:0]        op;
   dec_t              dec;
   logic [REG_AW-1:0] rs_f, rt_f, rd_f;
   logic [REG_AW-1:0] rs_addr, rt_addr, dst_addr;
   logic [DATA_W-1:0] rs_val, rt_val, imm;
   id_ex_t            ctrl_d, ctrl_q;
   id_state_t         state_q, state_d;
   logic              live_q;
   logic              out_free, hz, accept;

   // Unused sources are reported as r0 so EX never forwards into an operand it ignores.
   assign op       = if_inst[OPC_HI:OPC_LO];
   assign dec      = decode_op(op);
   assign rs_f     = REG_AW'(if_inst[RS_HI:RS_LO]);
   assign rt_f     = REG_AW'(if_inst[RT_HI:RT_LO]);
   assign rd_f     = REG_AW'(if_inst[RD_HI:RD_LO]);
   assign rs_addr  = dec.use_rs ? rs_f : '0;
   assign rt_addr  = dec.use_rt ? rt_f : '0;
   assign dst_addr = dec.dst_rd ? rd_f : (dec.dst_rt ? rt_f : '0);
   assign imm      = DATA_W'($signed(if_inst[IMM_HI:IMM_LO]));

   assign ctrl_d = '{opcode:  op,
                     we:      (dst_addr != '0),
                     is_load: dec.is_load,
                     illegal: dec.illegal};

   regfile_bypass #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rf (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_a (rs_addr),
      .rd_data_a (rs_val),
      .rd_addr_b (rt_addr),
      .rd_data_b (rt_val),
      .wr_en     (wb_we),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data)
   );

   // A used source of r0 can never match, since a load with dst r0 has ex_we cleared.
   assign hz = ex_valid & ctrl_q.is_load & ctrl_q.we & if_valid &
               ((dec.use_rs & (rs_addr == ex_dst_addr)) |
                (dec.use_rt & (rt_addr == ex_dst_addr)));

   assign out_free = !ex_valid | ex_ready;
   assign if_ready = live_q & out_free & !hz & !flush & (state_q == RUN);
   assign accept   = if_valid & if_ready;
   assign halted   = (state_q == HALTED);

   assign ex_opcode  = ctrl_q.opcode;
   assign ex_we      = ctrl_q.we;
   assign ex_is_load = ctrl_q.is_load;
   assign ex_illegal = ctrl_q.illegal;

   // NOTE: every variable of an always_comb block gets its default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:       if (accept && op == OP_HALT) state_d = HALT_PEND;
         HALT_PEND: begin
            if (flush)                      state_d = RUN;
            else if (ex_valid && ex_ready)  state_d = HALTED;
         end
         HALTED:    state_d = HALTED;
         default:   state_d = RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the values
   // from before the edge, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ctrl_q      <= '0;
         ex_rs_addr  <= '0;
         ex_rt_addr  <= '0;
         ex_rs_val   <= '0;
         ex_rt_val   <= '0;
         ex_dst_addr <= '0;
         ex_imm      <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (out_free) begin
         ex_valid    <= accept;
         ex_pc       <= if_pc;
         ctrl_q      <= ctrl_d;
         ex_rs_addr  <= rs_addr;
         ex_rt_addr  <= rt_addr;
         ex_rs_val   <= rs_val;
         ex_rt_val   <= rt_val;
         ex_dst_addr <= dst_addr;
         ex_imm      <= imm;
      end
   end

`ifdef ID_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (if_valid && !if_ready && state_q == RUN && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         // A bubble is the output register loading an empty slot because of the hazard.
         if (hz && out_free && !flush && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_stage_hs.sv
// Self-checking bench for id_stage_hs: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the decode stage.
module tb_id_stage_hs;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int PW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_valid, if_ready;
   logic [PW-1:0] if_pc;
   logic [31:0]   if_inst;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          flush;
   logic          ex_valid, ex_ready;
   logic [PW-1:0] ex_pc;
   logic [5:0]    ex_opcode;
   logic [AW-1:0] ex_rs_addr, ex_rt_addr, ex_dst_addr;
   logic [DW-1:0] ex_rs_val, ex_rt_val, ex_imm;
   logic          ex_we, ex_is_load, ex_illegal, halted;

   id_stage_hs #(.DATA_W(DW), .NUM_REGS(NR), .PC_W(PW)) dut (
      .clk(clk), .reset(reset),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
      .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
      .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_dst_addr(ex_dst_addr),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_imm(ex_imm),
      .ex_illegal(ex_illegal), .halted(halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_regs [NR];
   bit            m_live, m_valid, m_we, m_ld, m_ill;
   int            m_state;     // 0 running, 1 halt waiting for hand-off, 2 halted
   logic [PW-1:0] m_pc;
   logic [5:0]    m_op;
   logic [AW-1:0] m_rs, m_rt, m_dst;
   logic [DW-1:0] m_rsv, m_rtv, m_imm;

   // dst_kind: 0 no destination, 1 rd field, 2 rt field
   function automatic void classify(input logic [5:0] op, output bit rs_used,
                                    output bit rt_used, output int dst_kind, output bit ill);
      rs_used = 0; rt_used = 0; dst_kind = 0; ill = 0;
      if (op <= 6'h0B && !op[0])                       begin rs_used = 1; rt_used = 1; dst_kind = 1; end
      else if ((op <= 6'h0B && op[0]) || op == 6'h0C)  begin rs_used = 1; dst_kind = 2; end
      else if (op == 6'h0D || op == 6'h0F)             begin rs_used = 1; rt_used = 1; end
      else if (op == 6'h0E || op == 6'h10)             rs_used = 1;
      else if (op != 6'h11)                            ill = 1;
   endfunction

   function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wb_we && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic bit exp_ready();
      bit ru, tu, ill, hz;
      int dk;
      classify(if_inst[31:26], ru, tu, dk, ill);
      hz = m_valid && m_ld && m_we && if_valid &&
           ((ru && if_inst[25:21] == m_dst) || (tu && if_inst[20:16] == m_dst));
      return m_live && m_state == 0 && (!m_valid || ex_ready) && !hz && !flush;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_live = 0; m_valid = 0; m_state = 0;
   endtask

   task automatic model_step();
      bit ru, tu, ill, rdy, acc, free;
      int dk, nxt;
      rdy  = exp_ready();
      acc  = if_valid && rdy;
      free = !m_valid || ex_ready;
      nxt  = m_state;
      if (m_state == 1 && flush)                     nxt = 0;
      else if (m_state == 1 && m_valid && ex_ready)  nxt = 2;
      else if (m_state == 0 && acc && if_inst[31:26] == 6'h11) nxt = 1;
      if (flush) m_valid = 0;
      else if (free) begin
         m_valid = acc;
         if (acc) begin
            classify(if_inst[31:26], ru, tu, dk, ill);
            m_op  = if_inst[31:26];
            m_pc  = if_pc;
            m_rs  = ru ? if_inst[25:21] : 5'd0;
            m_rt  = tu ? if_inst[20:16] : 5'd0;
            m_dst = (dk == 1) ? if_inst[15:11] : (dk == 2) ? if_inst[20:16] : 5'd0;
            m_we  = (m_dst != 0);
            m_ld  = (m_op == 6'h0C);
            m_ill = ill;
            m_rsv = read_reg(m_rs);
            m_rtv = read_reg(m_rt);
            m_imm = {{16{if_inst[15]}}, if_inst[15:0]};
         end
      end
      m_state = nxt;
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_live = 1;
   endtask

   task automatic compare();
      check("if_ready", if_ready, exp_ready());
      check("ex_valid", ex_valid, m_valid);
      check("halted", halted, m_state == 2);
      if (m_valid) begin
         check("ex_pc", ex_pc, m_pc);
         check("ex_opcode", ex_opcode, m_op);
         check("ex_rs_addr", ex_rs_addr, m_rs);
         check("ex_rt_addr", ex_rt_addr, m_rt);
         check("ex_rs_val", ex_rs_val, m_rsv);
         check("ex_rt_val", ex_rt_val, m_rtv);
         check("ex_dst_addr", ex_dst_addr, m_dst);
         check("ex_we", ex_we, m_we);
         check("ex_is_load", ex_is_load, m_ld);
         check("ex_imm", ex_imm, m_imm);
         check("ex_illegal", ex_illegal, m_ill);
      end
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_if_ready", if_ready, 1'b0);
      check("rst_ex_pc", ex_pc, '0);
      check("rst_ex_imm", ex_imm, '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] r_inst(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'h0};
   endfunction

   function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic present(input logic [PW-1:0] pc, input logic [31:0] inst);
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = inst;
   endtask

   function automatic logic [31:0] rand_inst();
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 99);
      if (r < 2)       op = 6'h11;
      else if (r < 6)  op = 6'($urandom_range(18, 63));
      else if (r < 26) op = 6'h0C;
      else             op = 6'($urandom_range(0, 16));
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
   endfunction

   initial begin
      int halted_for;
      reset = 1'b1; if_valid = 0; if_pc = '0; if_inst = '0;
      wb_we = 0; wb_addr = '0; wb_data = '0; flush = 0; ex_ready = 1;
      do_reset();
      tick();

      // WB write then read through the ADD
      wb_we = 1; wb_addr = 5'd3; wb_data = 32'h1234;
      tick();
      wb_we = 0;
      present(32'h100, r_inst(6'h00, 5'd3, 5'd0, 5'd5));
      tick();
      check("add_valid", ex_valid, 1'b1);
      check("add_rs_val", ex_rs_val, 32'h1234);
      check("add_rt_val", ex_rt_val, 32'h0);
      check("add_dst", ex_dst_addr, 5'd5);
      check("add_we", ex_we, 1'b1);

      // ADDI with negative immediate, rs bypassed from a same-cycle WB write
      wb_we = 1; wb_addr = 5'd1; wb_data = 32'hAB;
      present(32'h104, i_inst(6'h01, 5'd1, 5'd4, 16'hFFF0));
      tick();
      wb_we = 0;
      check("addi_imm", ex_imm, 32'hFFFF_FFF0);
      check("addi_dst", ex_dst_addr, 5'd4);
      check("addi_bypass", ex_rs_val, 32'hAB);

      // Load-use: exactly one bubble
      present(32'h108, i_inst(6'h0C, 5'd0, 5'd7, 16'h4));
      tick();
      present(32'h10C, r_inst(6'h00, 5'd7, 5'd2, 5'd9));
      #1 check("lu_if_ready", if_ready, 1'b0);
      tick();
      check("lu_bubble", ex_valid, 1'b0);
      tick();
      check("lu_issue_valid", ex_valid, 1'b1);
      check("lu_issue_pc", ex_pc, 32'h10C);

      // Load followed by an independent instruction: no bubble
      present(32'h110, i_inst(6'h0C, 5'd0, 5'd7, 16'h8));
      tick();
      present(32'h114, r_inst(6'h00, 5'd8, 5'd2, 5'd9));
      #1 check("nolu_if_ready", if_ready, 1'b1);
      tick();
      check("nolu_pc", ex_pc, 32'h114);

      // EX back-pressure for three cycles
      ex_ready = 0;
      present(32'h118, r_inst(6'h02, 5'd1, 5'd3, 5'd2));
      repeat (3) tick();
      check("stall_pc", ex_pc, 32'h114);
      check("stall_if_ready", if_ready, 1'b0);
      ex_ready = 1;

      // Undefined opcode
      present(32'h11C, {6'h3F, 5'd1, 5'd2, 5'd3, 11'h0});
      tick();
      check("ill_flag", ex_illegal, 1'b1);
      check("ill_we", ex_we, 1'b0);

      // Writes to r0 are dropped
      wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
      if_valid = 0;
      tick();
      wb_we = 0;
      present(32'h120, r_inst(6'h0F, 5'd0, 5'd3, 5'd0));
      tick();
      check("r0_read", ex_rs_val, 32'h0);
      check("r3_read", ex_rt_val, 32'h1234);

      // HALT killed by a flush in its hand-off cycle
      present(32'h130, {6'h11, 26'h0});
      tick();
      present(32'h134, r_inst(6'h00, 5'd1, 5'd1, 5'd1));
      flush = 1;
      tick();
      flush = 0;
      check("hflush_halted", halted, 1'b0);
      #1 check("hflush_if_ready", if_ready, 1'b1);

      // HALT delivered for real
      present(32'h140, {6'h11, 26'h0});
      tick();
      ex_ready = 0;
      tick();
      ex_ready = 1;
      tick();
      check("halt_halted", halted, 1'b1);
      check("halt_ex_valid", ex_valid, 1'b0);
      repeat (5) begin
         present(32'h150, r_inst(6'h00, 5'd1, 5'd1, 5'd1));
         ex_ready = 1'($urandom);
         tick();
      end
      check("halt_sticky_ready", if_ready, 1'b0);
      do_reset();
      check("after_reset_halted", halted, 1'b0);
      tick();

      // Randomized traffic
      halted_for = 0;
      for (int n = 0; n < 4000; n++) begin
         if_valid = ($urandom_range(0, 99) < 75);
         if_pc    = $urandom;
         if_inst  = rand_inst();
         ex_ready = ($urandom_range(0, 99) < 70);
         flush    = ($urandom_range(0, 99) < 5);
         wb_we    = ($urandom_range(0, 99) < 40);
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         halted_for = (m_state == 2) ? halted_for + 1 : 0;
         if (halted_for > 10 || $urandom_range(0, 999) < 3) begin
            do_reset();
            halted_for = 0;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
Parametrised instruction-decode stage for the 5-stage pipeline, sitting between IF and EX.
- Decodes the 6-bit-opcode ISA (R/I formats) and owns the register file with write-through bypass from WB.
- Uses a valid/ready handshake on both sides.
- Detects load-use hazards and inserts one bubble per hazard.
- Supports a synchronous flush from EX.
- Stops fetch permanently once HALT is handed to EX.

Parameters:
DATA_W, 32, datapath and register width; immediate sign-extended to DATA_W
NUM_REGS, 32, register count; REG_AW = $clog2(NUM_REGS); register 0 hardwired to zero
PC_W, 32, program-counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_valid  in  1  IF presents an instruction
if_ready  out  1  ID accepts the instruction this cycle
if_pc  in  PC_W  PC of presented instruction
if_inst  in  32  instruction word
wb_we  in  1  WB register write enable
wb_addr  in  REG_AW  WB destination
wb_data  in  DATA_W  WB data
flush  in  1  EX redirect: kill the ID contents
ex_valid  out  1  output record valid
ex_ready  in  1  EX accepts the record
ex_pc  out  PC_W  PC
ex_opcode  out  6  opcode
ex_rs_addr, ex_rt_addr  out  REG_AW each  source indices, for EX forwarding
ex_rs_val, ex_rt_val  out  DATA_W each  source operands
ex_dst_addr  out  REG_AW  destination index
ex_we  out  1  instruction writes a register
ex_is_load  out  1  LDW
ex_imm  out  DATA_W  sign-extended inst[15:0]
ex_illegal  out  1  undefined opcode
halted  out  1  HALT delivered to EX

Behaviour:
- Decode (combinational from if_inst):
  - R-type ADD/SUB/MUL/OR/AND/XOR (0x00,02,04,06,08,0A): sources rs=[25:21], rt=[20:16]; dst rd=[15:11]; we=1.
  - I-type ADDI/SUBI/MULI/ORI/ANDI/XORI/LDW (odd 0x01..0x0B, 0x0C): source rs; dst rt; we=1. LDW sets is_load.
  - STW (0x0D) and BEQ (0x0F): sources rs, rt; we=0.
  - BZ (0x0E) and JR (0x10): source rs only; we=0.
  - HALT (0x11): no sources; we=0.
  - Any other opcode: we=0, illegal=1, still passed to EX.
  - A dst of 0 forces we=0.
- Register file:
  - NUM_REGS x DATA_W; reset clears all entries.
  - A WB write updates the entry at the next edge; writes to r0 are ignored.
  - Read of r0 returns 0.
  - Read of wb_addr while wb_we=1 returns wb_data in the same cycle (bypass).
- Output register:
  - out_free = !ex_valid | ex_ready.
  - The register loads on out_free; otherwise it holds all fields.
  - On load, ex_valid = accept (bubble when 0).
- Load-use hazard: hz = ex_valid & ex_is_load & ex_we & (ex_dst_addr matches a used source of if_inst) & if_valid.
- if_ready = out_free & !hz & !flush & state==RUN.
- accept = if_valid & if_ready.
- Latency: one cycle from accept to ex_valid.
- Hazard timing: a hazard yields exactly one bubble, since the load leaves the output register and hz clears.
- Flush (synchronous):
  - The next edge sets ex_valid=0, overriding ex_ready.
  - Nothing is accepted in a flush cycle.
  - State HALT_PEND returns to RUN.
- FSM:
  - RUN: accepting HALT goes to HALT_PEND.
  - HALT_PEND: if_ready=0. Flush goes to RUN. Otherwise, once the HALT record is handed off (ex_valid & ex_ready), go to HALTED.
  - HALTED: halted=1, if_ready=0, ex_valid=0. Only reset exits.
  - Flush and hand-off in the same cycle: flush wins.
- Reset: all outputs 0, state RUN, register file 0. if_ready=1 after the first edge with reset high.
- Reset mid-operation discards all in-flight state asynchronously.

Optional Feature:
ID_PERF_CNT_EN:
- Defined: adds output stall_cnt (32 bits) and output bubble_cnt (32 bits). Both reset to 0.
  - stall_cnt increments on each cycle with if_valid & !if_ready & state==RUN.
  - bubble_cnt increments on each load-use bubble inserted.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent.

Decomposition:
- Package isa_pkg: opcode enum (OP_ADD..OP_HALT), instruction field positions, id_state_t {RUN, HALT_PEND, HALTED}, packed struct id_ex_t for the output record.
- Sub-module regfile_bypass: parameters DATA_W, NUM_REGS; 2 read ports, 1 write port, write-through bypass, r0 zero.

Test Plan:
- Write r3=0x1234 via WB, then decode ADD rs=3 rt=0 rd=5 -> next cycle ex_valid=1, ex_rs_val=0x1234, ex_rt_val=0, ex_dst_addr=5, ex_we=1.
- ADDI rt=4 imm=0xFFF0 -> ex_imm=0xFFFFFFF0, ex_dst_addr=4. Same cycle as WB write r1=0xAB with the instruction's rs=1 -> ex_rs_val=0xAB.
- LDW rt=7, then ADD rs=7 -> if_ready=0 for one cycle, one bubble (ex_valid=0), then ADD issues. Repeat with ADD rs=8 -> no bubble.
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* fields stable, if_ready=0.
- HALT accepted with flush asserted the same cycle as hand-off -> halted stays 0, state RUN. Without flush -> halted=1, if_ready=0 until reset.
- Opcode 0x3F -> ex_illegal=1, ex_we=0. WB write to r0 -> r0 still reads 0.
